// File: rtl/inert_sensor_serf_pkg.sv
// Shared types and register addresses for the inertial-sensor SPI serf model.
package inert_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } serf_state_t;

  localparam logic [6:0] ADDR_INT1_CTRL = 7'h0D;
  localparam logic [6:0] ADDR_WHO       = 7'h0F;
  localparam logic [6:0] ADDR_CTRL2_G   = 7'h11;
  localparam logic [6:0] ADDR_CTRL7_G   = 7'h14;
  localparam logic [6:0] ADDR_STATUS    = 7'h1E;
  localparam logic [6:0] ADDR_YAWL      = 7'h26;
  localparam logic [6:0] ADDR_YAWH      = 7'h27;

  // Gyro produces samples only with its data-ready routed to INT1 and a non-zero ODR code.
  function automatic logic sample_enabled(input logic int1_drdy_g, input logic [3:0] odr_g);
    return int1_drdy_g && (odr_g != 4'h0);
  endfunction

endpackage

// File: rtl/inert_sensor_serf_sync.sv
// Pad synchronizers for the SPI pins: two metastability flops plus one history flop each.
module spi_serf_sync (
  input  logic i_clk,
  input  logic i_ss_n,
  input  logic i_sclk,
  input  logic i_mosi,
  output logic o_ss_n_s,
  output logic o_ss_fall,
  output logic o_ss_rise,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_mosi_s
);

  logic [2:0] r_ss;
  logic [2:0] r_sclk;
  logic [2:0] r_mosi;

  // Left unreset so a select held low across rst never looks like a fresh frame start.
  always_ff @(posedge i_clk) begin
    r_ss   <= {r_ss[1:0],   i_ss_n};
    r_sclk <= {r_sclk[1:0], i_sclk};
    r_mosi <= {r_mosi[1:0], i_mosi};
  end

  assign o_ss_n_s    = r_ss[1];
  assign o_ss_fall   = r_ss[2] & ~r_ss[1];
  assign o_ss_rise   = ~r_ss[2] & r_ss[1];
  assign o_sclk_rise = ~r_sclk[2] & r_sclk[1];
  assign o_sclk_fall = r_sclk[2] & ~r_sclk[1];
  assign o_mosi_s    = r_mosi[2];

endmodule

// File: rtl/inert_sensor_serf.sv
// SPI serf model of the 6-axis inertial sensor: 16-bit frames, config regs,
// yaw-rate sampling with data-ready INT and sticky overrun.
module inert_sensor_serf
  import inert_pkg::*;
#(
  parameter logic [15:0] ODR_CYCLES = 16'd2048,
  parameter logic [7:0]  WHO_AM_I   = 8'h6A
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               SS_n,
  input  logic               SCLK,
  input  logic               MOSI,
  output logic               MISO,
  output logic               INT,
  input  logic signed [15:0] yaw_in,
  output logic               ovrrun
);

  logic w_ss_n_s, w_ss_fall, w_ss_rise, w_sclk_rise, w_sclk_fall, w_mosi_s;

  spi_serf_sync u_sync (
    .i_clk       (clk),
    .i_ss_n      (SS_n),
    .i_sclk      (SCLK),
    .i_mosi      (MOSI),
    .o_ss_n_s    (w_ss_n_s),
    .o_ss_fall   (w_ss_fall),
    .o_ss_rise   (w_ss_rise),
    .o_sclk_rise (w_sclk_rise),
    .o_sclk_fall (w_sclk_fall),
    .o_mosi_s    (w_mosi_s)
  );

  serf_state_t r_state, w_next;
  logic        w_frame_start, w_shift_en, w_commit;

  logic [15:0] r_rx_shft, r_tx_shft;
  logic [4:0]  r_bcnt;
  logic [7:0]  r_int1_ctrl, r_ctrl2_g, r_ctrl7_g;
  logic [15:0] r_yaw;
  logic        r_int, r_ovrrun, r_tick_pend;
  logic [15:0] r_timer;

  logic [7:0]  w_rdata;
  logic        w_frame_ok, w_wr, w_clr_int;
  logic        w_sample_en, w_tick, w_idle_free, w_apply, w_defer;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_ss_fall) w_next = SHIFT;
      SHIFT:   if (w_ss_rise) w_next = COMMIT;
      COMMIT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_frame_start = 1'b0;
    w_shift_en    = 1'b0;
    w_commit      = 1'b0;
    case (r_state)
      IDLE:    w_frame_start = w_ss_fall;
      SHIFT:   w_shift_en    = 1'b1;
      COMMIT:  w_commit      = 1'b1;
      default: ;
    endcase
  end

  // Read data is looked up once the command byte is in, from its low 7 bits.
  always_comb begin
    w_rdata = '0;
    case (r_rx_shft[6:0])
      ADDR_INT1_CTRL: w_rdata = r_int1_ctrl;
      ADDR_WHO:       w_rdata = WHO_AM_I;
      ADDR_CTRL2_G:   w_rdata = r_ctrl2_g;
      ADDR_CTRL7_G:   w_rdata = r_ctrl7_g;
      ADDR_STATUS:    w_rdata = {6'b0, r_ovrrun, r_int};
      ADDR_YAWL:      w_rdata = r_yaw[7:0];
      ADDR_YAWH:      w_rdata = r_yaw[15:8];
      default:        w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || w_frame_start) begin
      r_rx_shft <= '0;
      r_tx_shft <= '0;
      r_bcnt    <= '0;
    end else if (w_shift_en) begin
      if (w_sclk_rise && (r_bcnt != 5'd16)) begin
        r_rx_shft <= {r_rx_shft[14:0], w_mosi_s};
        r_bcnt    <= r_bcnt + 5'd1;
      end
      if (w_sclk_fall) begin
        if (r_bcnt == 5'd8)
          r_tx_shft <= {w_rdata, 8'h00};
        else if ((r_bcnt >= 5'd1) && (r_bcnt <= 5'd15))
          r_tx_shft <= {r_tx_shft[14:0], 1'b0};
      end
    end
  end

  assign w_frame_ok = w_commit && (r_bcnt == 5'd16);
  assign w_wr       = w_frame_ok && !r_rx_shft[15];
  assign w_clr_int  = w_frame_ok && r_rx_shft[15] && (r_rx_shft[14:8] == ADDR_YAWH);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_int1_ctrl <= '0;
      r_ctrl2_g   <= '0;
      r_ctrl7_g   <= '0;
    end else if (w_wr) begin
      case (r_rx_shft[14:8])
        ADDR_INT1_CTRL: r_int1_ctrl <= r_rx_shft[7:0];
        ADDR_CTRL2_G:   r_ctrl2_g   <= r_rx_shft[7:0];
        ADDR_CTRL7_G:   r_ctrl7_g   <= r_rx_shft[7:0];
        default: ;
      endcase
    end
  end

  assign w_sample_en = sample_enabled(r_int1_ctrl[1], r_ctrl2_g[7:4]);
  assign w_tick      = w_sample_en && (r_timer == (ODR_CYCLES - 16'd1));
  assign w_idle_free = (r_state == IDLE) && w_ss_n_s;

  // A tick landing inside a frame is parked and applied in COMMIT so read bytes never tear.
  assign w_apply = w_sample_en &&
                   ((w_tick && w_idle_free) || (w_commit && (w_tick || r_tick_pend)));
  assign w_defer = w_tick && !w_apply;

  always_ff @(posedge clk) begin
    if (rst || !w_sample_en) begin
      r_timer     <= '0;
      r_tick_pend <= 1'b0;
    end else begin
      r_timer <= w_tick ? '0 : r_timer + 16'd1;
      if (w_apply)      r_tick_pend <= 1'b0;
      else if (w_defer) r_tick_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_yaw    <= '0;
      r_ovrrun <= 1'b0;
    end else if (w_apply) begin
      r_yaw <= yaw_in;
      if (r_int && !w_clr_int) r_ovrrun <= 1'b1;
    end
  end

  // Set has priority over the COMMIT clear, so a deferred tick is never lost.
  always_ff @(posedge clk) begin
    if (rst || !w_sample_en) r_int <= 1'b0;
    else if (w_apply)        r_int <= 1'b1;
    else if (w_clr_int)      r_int <= 1'b0;
  end

  assign MISO   = r_tx_shft[15];
  assign INT    = r_int;
  assign ovrrun = r_ovrrun;

endmodule

// File: tb/tb_inert_sensor_serf.sv
// Self-checking bench for inert_sensor_serf: a mode-3 SPI monarch with a scoreboard of expected read words.
module tb_inert_sensor_serf;

  localparam int ODR = 1024;
  localparam int H   = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        SS_n = 1'b1;
  logic        SCLK = 1'b1;
  logic        MOSI = 1'b0;
  logic        MISO, INT, ovrrun;
  logic [15:0] yaw_in = '0;

  int          n_chk = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          t_rise = 0;
  logic [15:0] exp_q[$];

  inert_sensor_serf #(
    .ODR_CYCLES (16'd1024),
    .WHO_AM_I   (8'h6A)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .SS_n   (SS_n),
    .SCLK   (SCLK),
    .MOSI   (MOSI),
    .MISO   (MISO),
    .INT    (INT),
    .yaw_in (yaw_in),
    .ovrrun (ovrrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

  // Mode 3: drive MOSI on SCLK fall, capture MISO on SCLK rise. Returns right at SS_n rise.
  task automatic spi_xfer(input logic [15:0] cmd, input int nbits, input int hold,
                          output logic [15:0] rd);
    rd   = '0;
    SS_n = 1'b0;
    repeat (H + hold) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      SCLK = 1'b0;
      MOSI = (i < 16) ? cmd[15-i] : 1'b0;
      repeat (H) @(negedge clk);
      SCLK = 1'b1;
      if (i < 16) rd = {rd[14:0], MISO};
      repeat (H) @(negedge clk);
    end
    repeat (H) @(negedge clk);
    SS_n   = 1'b1;
    t_rise = cyc;
  endtask

  task automatic do_read(input logic [6:0] addr, output logic [15:0] rd);
    spi_xfer({1'b1, addr, 8'h00}, 16, 0, rd);
    repeat (6) @(negedge clk);
  endtask

  task automatic do_write(input logic [15:0] cmd, input int nbits);
    logic [15:0] rd;
    spi_xfer(cmd, nbits, 0, rd);
    repeat (6) @(negedge clk);
  endtask

  task automatic wait_int(input logic lvl, input int limit, output int dt);
    dt = -1;
    for (int i = 0; i < limit; i++) begin
      if (INT === lvl) begin
        dt = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [15:0] rd, e;
    int bad;
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({MISO, INT, ovrrun} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_outputs: got MISO/INT/ovrrun=%b expected 000", {MISO, INT, ovrrun});
    end
    exp_q.push_back(16'h006A);
    do_read(7'h0F, rd);
    e = exp_q.pop_front();
    n_chk++;
    if (rd !== e) begin
      n_err++;
      $display("FAIL who_am_i: got %h expected %h", rd, e);
    end
    bad = 0;
    repeat (4 * ODR) begin
      @(negedge clk);
      if (INT !== 1'b0) bad++;
    end
    n_chk++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL int_unconfigured: got %0d cycles with INT high expected 0", bad);
    end
  endtask

  task automatic test_config();
    logic [15:0] rd, e;
    logic [6:0]  addrs[5];
    logic [7:0]  vals[5];
    int dt, d, t_en;
    addrs = '{7'h26, 7'h27, 7'h0D, 7'h11, 7'h14};
    vals  = '{8'h34, 8'h12, 8'h02, 8'h60, 8'h40};
    yaw_in = 16'h1234;
    do_write(16'h0D02, 16);
    spi_xfer(16'h1160, 16, 0, rd);
    t_en = t_rise;
    d = -1;
    fork
      begin
        wait_int(1'b1, ODR + 40, dt);
        if (dt >= 0) d = cyc - t_en;
      end
      begin
        repeat (6) @(negedge clk);
        do_write(16'h1440, 16);
      end
    join
    n_chk++;
    if (d < ODR + 4 || d > ODR + 7) begin
      n_err++;
      $display("FAIL int_latency: got %0d cycles after SS_n rise expected %0d..%0d", d, ODR + 4, ODR + 7);
    end
    for (int i = 0; i < 2; i++) exp_q.push_back({8'h00, vals[i]});
    do_read(addrs[0], rd);
    e = exp_q.pop_front();
    n_chk++;
    if (rd !== e) begin
      n_err++;
      $display("FAIL yawL_read: got %h expected %h", rd, e);
    end
    spi_xfer({1'b1, addrs[1], 8'h00}, 16, 0, rd);
    n_chk++;
    if (INT !== 1'b1) begin
      n_err++;
      $display("FAIL int_before_clear: got %b expected 1", INT);
    end
    wait_int(1'b0, 12, dt);
    d = cyc - t_rise;
    n_chk++;
    if (dt < 0 || d < 4 || d > 5) begin
      n_err++;
      $display("FAIL int_clear_latency: got %0d (dt %0d) expected 4..5", d, dt);
    end
    repeat (6) @(negedge clk);
    e = exp_q.pop_front();
    n_chk++;
    if (rd !== e) begin
      n_err++;
      $display("FAIL yawH_read: got %h expected %h", rd, e);
    end
    for (int i = 2; i < 5; i++) begin
      exp_q.push_back({8'h00, vals[i]});
      do_read(addrs[i], rd);
      e = exp_q.pop_front();
      n_chk++;
      if (rd !== e) begin
        n_err++;
        $display("FAIL cfg_readback_%0d: got %h expected %h", i, rd, e);
      end
    end
  endtask

  task automatic test_overrun();
    logic [15:0] rd, e;
    logic [6:0]  addrs[2];
    logic [7:0]  vals[2];
    int dt;
    addrs = '{7'h1E, 7'h27};
    vals  = '{8'h03, 8'h80};
    yaw_in = 16'h8001;
    wait_int(1'b1, ODR + 20, dt);
    n_chk++;
    if (dt < 0) begin
      n_err++;
      $display("FAIL ovr_first_tick: got no INT expected INT within %0d cycles", ODR + 20);
    end
    repeat (ODR + 10) @(negedge clk);
    n_chk++;
    if (ovrrun !== 1'b1) begin
      n_err++;
      $display("FAIL ovrrun_flag: got %b expected 1", ovrrun);
    end
    for (int i = 0; i < 2; i++) exp_q.push_back({8'h00, vals[i]});
    for (int i = 0; i < 2; i++) begin
      do_read(addrs[i], rd);
      e = exp_q.pop_front();
      n_chk++;
      if (rd !== e) begin
        n_err++;
        $display("FAIL ovr_read_%0d: got %h expected %h", i, rd, e);
      end
    end
  endtask

  task automatic test_deferred();
    logic [15:0] rd, e;
    int dt, d, c_int;
    yaw_in = 16'h1111;
    wait_int(1'b1, ODR + 20, dt);
    c_int = cyc;
    n_chk++;
    if (dt < 0) begin
      n_err++;
      $display("FAIL defer_prep_tick: got no INT expected INT within %0d cycles", ODR + 20);
    end
    exp_q.push_back(16'h0011);
    do_read(7'h27, rd);
    e = exp_q.pop_front();
    n_chk++;
    if (rd !== e) begin
      n_err++;
      $display("FAIL defer_prep_read: got %h expected %h", rd, e);
    end
    repeat (c_int + ODR - 60 - cyc) @(negedge clk);
    exp_q.push_back(16'h0011);
    fork
      spi_xfer(16'hA600, 16, 150, rd);
      begin
        repeat (30) @(negedge clk);
        yaw_in = 16'h2222;
      end
    join
    n_chk++;
    if (INT !== 1'b0) begin
      n_err++;
      $display("FAIL defer_int_in_frame: got %b expected 0", INT);
    end
    wait_int(1'b1, 12, dt);
    d = cyc - t_rise;
    n_chk++;
    if (dt < 0 || d < 4 || d > 5) begin
      n_err++;
      $display("FAIL defer_int_latency: got %0d (dt %0d) expected 4..5", d, dt);
    end
    repeat (6) @(negedge clk);
    e = exp_q.pop_front();
    n_chk++;
    if (rd !== e) begin
      n_err++;
      $display("FAIL defer_old_byte: got %h expected %h", rd, e);
    end
    exp_q.push_back(16'h0022);
    exp_q.push_back(16'h0022);
    for (int i = 0; i < 2; i++) begin
      do_read((i == 0) ? 7'h26 : 7'h27, rd);
      e = exp_q.pop_front();
      n_chk++;
      if (rd !== e) begin
        n_err++;
        $display("FAIL defer_new_byte_%0d: got %h expected %h", i, rd, e);
      end
    end
  endtask

  task automatic test_abort();
    logic [15:0] rd, e;
    int dt;
    do_write(16'h0D00, 9);
    exp_q.push_back(16'h0002);
    do_read(7'h0D, rd);
    e = exp_q.pop_front();
    n_chk++;
    if (rd !== e) begin
      n_err++;
      $display("FAIL abort_int1_ctrl: got %h expected %h", rd, e);
    end
    do_write(16'h14A5, 18);
    exp_q.push_back(16'h00A5);
    do_read(7'h14, rd);
    e = exp_q.pop_front();
    n_chk++;
    if (rd !== e) begin
      n_err++;
      $display("FAIL long_frame_write: got %h expected %h", rd, e);
    end
    wait_int(1'b1, 2 * ODR, dt);
    n_chk++;
    if (dt < 0) begin
      n_err++;
      $display("FAIL abort_sampling: got no INT expected INT within %0d cycles", 2 * ODR);
    end
  endtask

  task automatic test_rst_midframe();
    logic [15:0] rd, rd_dummy, e;
    fork
      spi_xfer(16'h8F00, 16, 0, rd_dummy);
      begin
        repeat (102) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({MISO, INT, ovrrun} !== 3'b000) begin
          n_err++;
          $display("FAIL midframe_reset_outputs: got %b expected 000", {MISO, INT, ovrrun});
        end
        rst = 1'b0;
      end
    join
    repeat (6) @(negedge clk);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h006A);
    for (int i = 0; i < 2; i++) begin
      do_read((i == 0) ? 7'h0D : 7'h0F, rd);
      e = exp_q.pop_front();
      n_chk++;
      if (rd !== e) begin
        n_err++;
        $display("FAIL post_reset_read_%0d: got %h expected %h", i, rd, e);
      end
    end
    n_chk++;
    if ({INT, ovrrun} !== 2'b00) begin
      n_err++;
      $display("FAIL post_reset_flags: got %b expected 00", {INT, ovrrun});
    end
  endtask

  initial begin
    test_reset();
    test_config();
    test_overrun();
    test_deferred();
    test_abort();
    test_rst_midframe();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
